// File: rtl/exmem.sv
// rtl/exmem.sv - EX/MEM pipeline register with data-memory access sequencer (optional forwarding tap: EXMEM_FWD_EN)

module exmem #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_aluout,
  input  logic [WORD_W-1:0] ex_storedata,
  input  logic [WORD_W-1:0] ex_imm,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic [2:0]        ex_WBctrl,
  input  logic [2:0]        ex_Mctrl,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] aluout_out,
  output logic [WORD_W-1:0] imm_out,
  output logic [WORD_W-1:0] npc_out,
  output logic [WORD_W-1:0] dmemload_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [2:0]        WBctrl_out,
  output logic              halt_out,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [WORD_W-1:0] fwd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   aluout_q, storedata_q, imm_q, npc_q, dload_q;
  logic [REG_W-1:0]    dest_q;
  logic [2:0]          wbctrl_q;
  logic                ren_q, wen_q, halt_q;

  logic                in_access;
  logic                advance;
  logic                cap_ren, cap_wen;

  assign in_access = (state_q == ACCESS);
  assign mem_stall = in_access & ~dhit;
  assign advance   = ihit & ~mem_stall;

  // A bubble carries no memory op; a read+write combination degrades to a read.
  assign cap_ren = ~flush & ex_Mctrl[2];
  assign cap_wen = ~flush & ex_Mctrl[1] & ~ex_Mctrl[2];

  // Next state: a new instruction decides whether an access starts; otherwise
  // a completed access parks in DONE so it is never re-issued.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = (cap_ren | cap_wen) ? ACCESS : IDLE;
    end else if (in_access && dhit) begin
      state_d = DONE;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pipeline latch: captures EX results (or a zero bubble on flush) on advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      aluout_q    <= '0;
      storedata_q <= '0;
      imm_q       <= '0;
      npc_q       <= '0;
      dest_q      <= '0;
      wbctrl_q    <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      halt_q      <= 1'b0;
    end else if (advance) begin
      aluout_q    <= flush ? '0 : ex_aluout;
      storedata_q <= flush ? '0 : ex_storedata;
      imm_q       <= flush ? '0 : ex_imm;
      npc_q       <= flush ? '0 : ex_npc;
      dest_q      <= flush ? '0 : ex_dest;
      wbctrl_q    <= flush ? '0 : ex_WBctrl;
      ren_q       <= cap_ren;
      wen_q       <= cap_wen;
      halt_q      <= ~flush & ex_Mctrl[0];
    end
  end

  // Load data is held after the hit so the waiting instruction keeps it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dload_q <= '0;
    end else if (in_access && dhit && ren_q) begin
      dload_q <= dmemload;
    end
  end

  assign dmemREN      = in_access & ren_q;
  assign dmemWEN      = in_access & wen_q;
  assign dmemaddr     = aluout_q;
  assign dmemstore    = storedata_q;
  assign aluout_out   = aluout_q;
  assign imm_out      = imm_q;
  assign npc_out      = npc_q;
  assign dest_out     = dest_q;
  assign WBctrl_out   = wbctrl_q;
  assign halt_out     = halt_q;
  assign dmemload_out = in_access ? dmemload : dload_q;

`ifdef EXMEM_FWD_EN
  logic load_wait;
  assign load_wait = in_access & ren_q & ~dhit;
  assign fwd_valid = wbctrl_q[2] & (dest_q != '0) & ~load_wait;
  assign fwd_dest  = dest_q;
  assign fwd_data  = wbctrl_q[1] ? dmemload_out :
                     wbctrl_q[0] ? npc_q : aluout_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_exmem.sv
// tb/tb_exmem.sv - self-checking bench for exmem with a transaction-level reference model

module tb_exmem;
  localparam int W = 32;
  localparam int R = 5;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         ihit = 1'b0, dhit = 1'b0, flush = 1'b0;
  logic [W-1:0] ex_aluout = '0, ex_storedata = '0, ex_imm = '0, ex_npc = '0;
  logic [R-1:0] ex_dest = '0;
  logic [2:0]   ex_WBctrl = '0, ex_Mctrl = '0;
  logic [W-1:0] dmemload = '0;

  logic         dmemREN, dmemWEN, mem_stall, halt_out, fwd_valid;
  logic [W-1:0] dmemaddr, dmemstore, aluout_out, imm_out, npc_out, dmemload_out, fwd_data;
  logic [R-1:0] dest_out, fwd_dest;
  logic [2:0]   WBctrl_out;

  int checks = 0;
  int errors = 0;

  exmem #(.WORD_W(W), .REG_W(R)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .ex_aluout(ex_aluout), .ex_storedata(ex_storedata), .ex_imm(ex_imm), .ex_npc(ex_npc),
    .ex_dest(ex_dest), .ex_WBctrl(ex_WBctrl), .ex_Mctrl(ex_Mctrl), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .aluout_out(aluout_out), .imm_out(imm_out), .npc_out(npc_out),
    .dmemload_out(dmemload_out), .dest_out(dest_out), .WBctrl_out(WBctrl_out),
    .halt_out(halt_out), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  always #5 CLK = ~CLK;

  // Reference model: the instruction held in MEM and whether its access is still owed.
  logic [W-1:0] m_alu, m_sd, m_imm, m_npc, m_dload;
  logic [R-1:0] m_dest;
  logic [2:0]   m_wb;
  logic         m_ren, m_wen, m_halt, m_pending;

  task automatic model_reset();
    m_alu = '0; m_sd = '0; m_imm = '0; m_npc = '0; m_dload = '0;
    m_dest = '0; m_wb = '0; m_ren = 0; m_wen = 0; m_halt = 0; m_pending = 0;
  endtask

  function automatic logic exp_stall();
    return m_pending & ~dhit;
  endfunction

  function automatic logic [W-1:0] exp_dml();
    return m_pending ? dmemload : m_dload;
  endfunction

  function automatic logic exp_fvalid();
`ifdef EXMEM_FWD_EN
    return m_wb[2] && (m_dest != 0) && !(m_pending && m_ren && !dhit);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [R-1:0] exp_fdest();
`ifdef EXMEM_FWD_EN
    return m_dest;
`else
    return '0;
`endif
  endfunction

  function automatic logic [W-1:0] exp_fdata();
`ifdef EXMEM_FWD_EN
    if (m_wb[1]) return exp_dml();
    if (m_wb[0]) return m_npc;
    return m_alu;
`else
    return '0;
`endif
  endfunction

  // One clock edge: the pending access may complete, and a new instruction may enter.
  task automatic tick();
    logic         adv, hit, n_pend;
    logic [W-1:0] n_dload;
    hit     = m_pending && dhit;
    adv     = ihit && !(m_pending && !dhit);
    n_dload = (hit && m_ren) ? dmemload : m_dload;
    n_pend  = hit ? 1'b0 : m_pending;
    @(posedge CLK);
    m_dload   = n_dload;
    m_pending = n_pend;
    if (adv) begin
      if (flush) begin
        m_alu = '0; m_sd = '0; m_imm = '0; m_npc = '0; m_dest = '0; m_wb = '0;
        m_ren = 0; m_wen = 0; m_halt = 0;
      end else begin
        m_alu = ex_aluout; m_sd = ex_storedata; m_imm = ex_imm; m_npc = ex_npc;
        m_dest = ex_dest; m_wb = ex_WBctrl;
        m_ren = ex_Mctrl[2]; m_wen = ex_Mctrl[1] && !ex_Mctrl[2]; m_halt = ex_Mctrl[0];
      end
      m_pending = m_ren || m_wen;
    end
    #1;
  endtask

  task automatic set_ex(input logic [W-1:0] alu, input logic [W-1:0] sd, input logic [R-1:0] dest,
                        input logic [2:0] wb, input logic [2:0] mc);
    ex_aluout = alu; ex_storedata = sd; ex_imm = alu ^ 32'h0F0F_0000; ex_npc = alu + 4;
    ex_dest = dest; ex_WBctrl = wb; ex_Mctrl = mc;
  endtask

  task automatic test_reset();
    nRST = 0; ihit = 1; dhit = 1; flush = 0; dmemload = 32'hCAFE_F00D;
    set_ex(32'h40, 32'h1111, 5'd7, 3'b111, 3'b101);
    model_reset();
    #2;
    checks++; if (aluout_out !== 0) begin errors++; $display("FAIL reset_aluout got %h want 0", aluout_out); end
    @(posedge CLK); #1;
    checks++; if ({dmemREN, dmemWEN, mem_stall, halt_out} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {dmemREN, dmemWEN, mem_stall, halt_out}); end
    checks++; if (dmemload_out !== 0) begin errors++; $display("FAIL reset_dmemload_out got %h want 0", dmemload_out); end
    checks++; if ({dest_out, WBctrl_out} !== 8'h0) begin errors++; $display("FAIL reset_dest_wb got %h want 0", {dest_out, WBctrl_out}); end
    checks++; if ({fwd_valid, fwd_dest, fwd_data} !== '0) begin errors++; $display("FAIL reset_fwd got %h want 0", {fwd_valid, fwd_dest, fwd_data}); end
    ihit = 0; dhit = 0; set_ex(0, 0, 0, 0, 0);
    nRST = 1;
  endtask

  task automatic test_alu();
    set_ex(32'h10, 32'h0, 5'd3, 3'b100, 3'b000); ihit = 1;
    tick();
    ihit = 0;
    @(negedge CLK);
    checks++; if (aluout_out !== 32'h10) begin errors++; $display("FAIL alu_aluout got %h want 10", aluout_out); end
    checks++; if (dest_out !== 5'd3) begin errors++; $display("FAIL alu_dest got %0d want 3", dest_out); end
    checks++; if ({dmemREN, mem_stall} !== 2'b00) begin errors++; $display("FAIL alu_ren_stall got %b want 00", {dmemREN, mem_stall}); end
    checks++; if (fwd_valid !== exp_fvalid() || fwd_data !== exp_fdata()) begin errors++; $display("FAIL alu_fwd got %b/%h want %b/%h", fwd_valid, fwd_data, exp_fvalid(), exp_fdata()); end
    tick();
  endtask

  task automatic test_load_stall();
    int stalls = 0;
    set_ex(32'h40, 32'h0, 5'd5, 3'b110, 3'b100); ihit = 1;
    tick();
    set_ex(32'h99, 32'h0, 5'd7, 3'b100, 3'b000); dhit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (dmemREN && mem_stall) stalls++;
      checks++; if (dmemaddr !== 32'h40) begin errors++; $display("FAIL load_addr got %h want 40", dmemaddr); end
`ifdef EXMEM_FWD_EN
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL load_fwd_stalled got %b want 0", fwd_valid); end
`endif
      tick();
    end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL load_stall_cycles got %0d want 3", stalls); end
    dhit = 1; dmemload = 32'hDEAD_BEEF; ihit = 0;
    @(negedge CLK);
    checks++; if ({dmemREN, mem_stall} !== 2'b10) begin errors++; $display("FAIL load_hit_ren_stall got %b want 10", {dmemREN, mem_stall}); end
    checks++; if (dmemload_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_hit_data got %h want deadbeef", dmemload_out); end
`ifdef EXMEM_FWD_EN
    checks++; if ({fwd_valid, fwd_dest, fwd_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin errors++; $display("FAIL load_fwd got %b/%0d/%h want 1/5/deadbeef", fwd_valid, fwd_dest, fwd_data); end
`endif
    tick();
    dmemload = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      dhit = (i == 1);
      @(negedge CLK);
      checks++; if ({dmemREN, mem_stall} !== 2'b00) begin errors++; $display("FAIL load_done_ren_stall got %b want 00", {dmemREN, mem_stall}); end
      checks++; if (dmemload_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_hold got %h want deadbeef", dmemload_out); end
      tick();
    end
    dhit = 0; ihit = 1;
    tick();
    ihit = 0;
    @(negedge CLK);
    checks++; if (aluout_out !== 32'h99 || dmemREN !== 1'b0) begin errors++; $display("FAIL load_next_advance got %h/%b want 99/0", aluout_out, dmemREN); end
    tick();
  endtask

  task automatic test_store_same_cycle();
    int wen_cycles = 0;
    set_ex(32'h80, 32'h1234, 5'd0, 3'b000, 3'b010); ihit = 1;
    tick();
    set_ex(32'h2222, 32'h0, 5'd9, 3'b100, 3'b000); dhit = 1;
    @(negedge CLK);
    if (dmemWEN) wen_cycles++;
    checks++; if ({dmemaddr, dmemstore} !== {32'h80, 32'h1234}) begin errors++; $display("FAIL store_addr_data got %h/%h want 80/1234", dmemaddr, dmemstore); end
    checks++; if ({dmemREN, mem_stall} !== 2'b00) begin errors++; $display("FAIL store_ren_stall got %b want 00", {dmemREN, mem_stall}); end
    tick();
    dhit = 0; ihit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (dmemWEN) wen_cycles++;
      tick();
    end
    checks++; if (wen_cycles !== 1) begin errors++; $display("FAIL store_wen_cycles got %0d want 1", wen_cycles); end
    checks++; if (aluout_out !== 32'h2222) begin errors++; $display("FAIL store_next_captured got %h want 2222", aluout_out); end
  endtask

  task automatic test_flush();
    set_ex(32'h80, 32'hABCD, 5'd4, 3'b100, 3'b011); ihit = 1; flush = 1;
    tick();
    flush = 0; ihit = 0; set_ex(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL flush_wen got %b want 0", dmemWEN); end
      checks++; if ({WBctrl_out, dest_out, aluout_out, halt_out} !== '0) begin errors++; $display("FAIL flush_bubble got %h want 0", {WBctrl_out, dest_out, aluout_out, halt_out}); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    set_ex(32'h44, 32'h0, 5'd2, 3'b110, 3'b110); ihit = 1;
    tick();
    ihit = 0; dhit = 0;
    @(negedge CLK);
    checks++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b101) begin errors++; $display("FAIL illegal_rw_as_read got %b want 101", {dmemREN, dmemWEN, mem_stall}); end
    #2 nRST = 0;
    #1;
    checks++; if ({dmemREN, mem_stall, aluout_out, dest_out, WBctrl_out} !== '0) begin errors++; $display("FAIL async_reset got %h want 0", {dmemREN, mem_stall, aluout_out, dest_out, WBctrl_out}); end
    model_reset();
    @(posedge CLK); #1;
    nRST = 1;
    @(negedge CLK);
    checks++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin errors++; $display("FAIL after_reset_idle got %b want 000", {dmemREN, dmemWEN, mem_stall}); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ihit = ($urandom_range(0, 3) != 0);
      dhit = ($urandom_range(0, 9) < 4);
      flush = ($urandom_range(0, 9) == 0);
      dmemload = $urandom;
      set_ex($urandom, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      @(negedge CLK);
      checks++; if ({dmemREN, dmemWEN} !== {m_pending & m_ren, m_pending & m_wen}) begin errors++; $display("FAIL rnd_req cyc %0d got %b want %b", n, {dmemREN, dmemWEN}, {m_pending & m_ren, m_pending & m_wen}); end
      checks++; if (mem_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, mem_stall, exp_stall()); end
      checks++; if ({dmemaddr, dmemstore} !== {m_alu, m_sd}) begin errors++; $display("FAIL rnd_addr_store cyc %0d got %h/%h want %h/%h", n, dmemaddr, dmemstore, m_alu, m_sd); end
      checks++; if ({aluout_out, imm_out, npc_out} !== {m_alu, m_imm, m_npc}) begin errors++; $display("FAIL rnd_fields cyc %0d got %h/%h/%h want %h/%h/%h", n, aluout_out, imm_out, npc_out, m_alu, m_imm, m_npc); end
      checks++; if ({dest_out, WBctrl_out, halt_out} !== {m_dest, m_wb, m_halt}) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %h want %h", n, {dest_out, WBctrl_out, halt_out}, {m_dest, m_wb, m_halt}); end
      checks++; if (dmemload_out !== exp_dml()) begin errors++; $display("FAIL rnd_dmemload_out cyc %0d got %h want %h", n, dmemload_out, exp_dml()); end
      checks++; if ({fwd_valid, fwd_dest, fwd_data} !== {exp_fvalid(), exp_fdest(), exp_fdata()}) begin errors++; $display("FAIL rnd_fwd cyc %0d got %b/%0d/%h want %b/%0d/%h", n, fwd_valid, fwd_dest, fwd_data, exp_fvalid(), exp_fdest(), exp_fdata()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store_same_cycle();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem.md
# exmem

EX/MEM pipeline register with an integrated data-memory access sequencer. It latches execute-stage results and issues the data-memory read or write for the instruction it holds. It stalls the pipeline until `dhit`, then presents the load data and write-back fields to the MEM/WB latch. It sits between the execute stage and `memwb`, and drives the dcache request lines.

## Interface
Parameters:
- `WORD_W`, 32, datapath width.
- `REG_W`, 5, register-index width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `ihit`  in  1  instruction fetch complete; pipeline may advance.
- `dhit`  in  1  data access complete this cycle.
- `flush`  in  1  insert bubble instead of EX contents on advance.
- `ex_aluout`, `ex_storedata`, `ex_imm`, `ex_npc`  in  WORD_W each  EX results.
- `ex_dest`  in  REG_W  destination register.
- `ex_WBctrl`  in  3  {RegWr, MemToReg, LinkSel}.
- `ex_Mctrl`  in  3  {dREN, dWEN, halt}.
- `dmemload`  in  WORD_W  dcache read data.
- `dmemREN`, `dmemWEN`  out  1  dcache request.
- `dmemaddr`, `dmemstore`  out  WORD_W  dcache address and store data.
- `mem_stall`  out  1  to hazard unit; freezes IF/ID/EX.
- `aluout_out`, `imm_out`, `npc_out`, `dmemload_out`  out  WORD_W  to `memwb`.
- `dest_out`  out  REG_W;  `WBctrl_out`  out  3;  `halt_out`  out  1.
- `fwd_valid`  out  1;  `fwd_dest`  out  REG_W;  `fwd_data`  out  WORD_W  forwarding tap.

## Operation
- `advance = ihit & ~mem_stall`. Latched fields load only on `advance`.
- On `advance` with `flush=1`: all latched fields load 0, giving a bubble with no memory access and no write-back.
- On `advance` with `flush=0`: the `ex_*` fields are captured.
- FSM states:
  - IDLE: no pending access.
  - ACCESS: request outstanding.
  - DONE: access finished; instruction waiting to advance.
- Transitions:
  - IDLE/DONE + `advance`: next state is ACCESS if the captured dREN|dWEN is set, else IDLE. With no `advance`, state holds.
  - ACCESS + `dhit`: capture `dmemload` into internal `dload_q` when dREN. If `advance` in the same cycle, apply the IDLE/DONE rule for the new instruction; else go to DONE.
  - ACCESS + no `dhit`: hold.
- Memory request outputs:
  - `dmemREN`/`dmemWEN` = latched dREN/dWEN only in ACCESS, else 0. Never both 1.
  - `dmemaddr = aluout_out`; `dmemstore` = latched storedata.
- `mem_stall = (state==ACCESS) & ~dhit`.
- `dmemload_out` = `dmemload` in ACCESS, else `dload_q`.
- Latched dREN and dWEN both set is illegal. Treat it as a read only.
- `halt_out` is the latched halt bit. It never blocks advance.

## Timing
- Reset values: all latched fields, `dload_q`, and every output are 0; state is IDLE.
- Reset is async. Asserting `nRST` mid-ACCESS drops `dmemREN`/`dmemWEN` immediately and abandons the access.
- EX→MEM latency: 1 cycle. The request asserts in the cycle after capture.
- Minimum access: 1 cycle when `dhit` is returned the same cycle and `ihit` is high, so no stall.
- Each extra cycle without `dhit` adds one stall cycle.
- After `dhit`, the request deasserts in the next cycle unless a new memory instruction advances in. An access is never re-issued for the same instruction.
- `dhit` outside ACCESS is ignored.
- `flush` without `advance` is ignored; upstream holds `flush` until `advance`.

## Configuration
- `EXMEM_FWD_EN` defined:
  - `fwd_valid` = latched RegWr & (`dest_out`≠0).
  - `fwd_dest` = `dest_out`.
  - `fwd_data` = `dmemload_out` when MemToReg, else `npc_out` when LinkSel, else `aluout_out`.
  - `fwd_valid` is forced 0 while a load is in ACCESS without `dhit`.
- `EXMEM_FWD_EN` undefined: `fwd_valid`, `fwd_dest`, `fwd_data` are tied 0 and no forwarding logic is built.

## Test plan
- Reset mid-ACCESS with `dmemREN=1`: drop `nRST` → `dmemREN`, `mem_stall`, and all outputs read 0 asynchronously; state is IDLE after release.
- ALU instruction (aluout=0x10, dest=3, RegWr) with `ihit=1` → next cycle `aluout_out=0x10`, `dest_out=3`, `dmemREN=0`, `mem_stall=0`.
- Load addr 0x40, `dhit` after 3 cycles with data 0xDEADBEEF → `dmemREN=1` and `mem_stall=1` for 3 cycles. `dmemload_out` holds 0xDEADBEEF until the next advance, with no re-read.
- Store 0x1234 to 0x80 with `dhit` and `ihit` in the same cycle → `dmemWEN` high exactly one cycle; the following instruction is captured that cycle.
- `flush=1` with `ihit=1` while EX holds a store → bubble latched: `dmemWEN` never asserts and `WBctrl_out=0`.
- `EXMEM_FWD_EN` set, load to r5 → `fwd_valid=0` while stalled; `fwd_valid=1`, `fwd_dest=5`, `fwd_data`=load data from `dhit` onward.
